// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : 16-bit instruction decode with 8x16 register file, write-back
//            bypass and two-word immediate instructions.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        valid_out,
  output logic [4:0]  opcode_out,
  output logic [2:0]  rdst_out,
  output logic [15:0] rs1_data,
  output logic [15:0] rs2_data,
  output logic [15:0] imm_out,
  output logic        has_imm
);

  typedef enum logic [0:0] {
    ST_DECODE   = 1'b0,
    ST_WAIT_IMM = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_rf [8];
  logic [4:0]  r_pend_op;
  logic [2:0]  r_pend_rd;
  logic [15:0] r_pend_rs1;
  logic [15:0] r_pend_rs2;

  logic        w_accept;
  logic        w_is_imm;
  logic [15:0] w_rs1;
  logic [15:0] w_rs2;

  assign w_accept = instr_valid && !stall && !flush;
  assign w_is_imm = (instr_in[15:13] == 3'b110);

  // Same-cycle write-back is forwarded so the decode sees the newest value.
  assign w_rs1 = (wb_en && (wb_addr == instr_in[7:5])) ? wb_data : r_rf[instr_in[7:5]];
  assign w_rs2 = (wb_en && (wb_addr == instr_in[4:2])) ? wb_data : r_rf[instr_in[4:2]];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= 16'h0000;
      end
    end else if (wb_en) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_DECODE;
      valid_out  <= 1'b0;
      has_imm    <= 1'b0;
      opcode_out <= 5'd0;
      rdst_out   <= 3'd0;
      rs1_data   <= 16'h0000;
      rs2_data   <= 16'h0000;
      imm_out    <= 16'h0000;
      r_pend_op  <= 5'd0;
      r_pend_rd  <= 3'd0;
      r_pend_rs1 <= 16'h0000;
      r_pend_rs2 <= 16'h0000;
    end else if (flush) begin
      r_state   <= ST_DECODE;
      valid_out <= 1'b0;
      has_imm   <= 1'b0;
    end else if (!stall) begin
      if (!w_accept) begin
        valid_out <= 1'b0;
      end else if (r_state == ST_WAIT_IMM) begin
        // Second word is pure data; source values come from first-word accept.
        r_state    <= ST_DECODE;
        valid_out  <= 1'b1;
        has_imm    <= 1'b1;
        imm_out    <= instr_in;
        opcode_out <= r_pend_op;
        rdst_out   <= r_pend_rd;
        rs1_data   <= r_pend_rs1;
        rs2_data   <= r_pend_rs2;
      end else if (w_is_imm) begin
        r_state    <= ST_WAIT_IMM;
        valid_out  <= 1'b0;
        r_pend_op  <= instr_in[15:11];
        r_pend_rd  <= instr_in[10:8];
        r_pend_rs1 <= w_rs1;
        r_pend_rs2 <= w_rs2;
      end else begin
        valid_out  <= 1'b1;
        has_imm    <= 1'b0;
        imm_out    <= 16'h0000;
        opcode_out <= instr_in[15:11];
        rdst_out   <= instr_in[10:8];
        rs1_data   <= w_rs1;
        rs2_data   <= w_rs2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage with a per-cycle
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr_in = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = 3'd0;
  logic [15:0] wb_data = 16'h0000;
  logic        valid_out;
  logic [4:0]  opcode_out;
  logic [2:0]  rdst_out;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic [15:0] imm_out;
  logic        has_imm;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .valid_out(valid_out), .opcode_out(opcode_out),
    .rdst_out(rdst_out), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm_out(imm_out), .has_imm(has_imm)
  );

  always #5 clk = ~clk;

  // Reference model: instruction-level view of registers, pending first word
  // and the bundle that must be visible after each edge.
  logic [15:0] m_rf [8];
  bit          m_pend;
  logic [4:0]  m_p_op;
  logic [2:0]  m_p_rd;
  logic [15:0] m_p_a, m_p_b;
  logic        e_valid, e_has;
  logic [4:0]  e_op;
  logic [2:0]  e_rd;
  logic [15:0] e_a, e_b, e_imm;

  function automatic logic [15:0] rd_src(input logic [2:0] idx);
    if (wb_en && wb_addr == idx) return wb_data;
    return m_rf[idx];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_pend = 1'b0;
      e_valid = 1'b0; e_has = 1'b0; e_op = 5'd0; e_rd = 3'd0;
      e_a = 16'h0000; e_b = 16'h0000; e_imm = 16'h0000;
    end else begin
      if (flush) begin
        e_valid = 1'b0; e_has = 1'b0; m_pend = 1'b0;
      end else if (!stall) begin
        if (!instr_valid) begin
          e_valid = 1'b0;
        end else if (m_pend) begin
          e_valid = 1'b1; e_has = 1'b1; e_imm = instr_in;
          e_op = m_p_op; e_rd = m_p_rd; e_a = m_p_a; e_b = m_p_b;
          m_pend = 1'b0;
        end else if (instr_in[15:13] == 3'b110) begin
          e_valid = 1'b0; m_pend = 1'b1;
          m_p_op = instr_in[15:11]; m_p_rd = instr_in[10:8];
          m_p_a = rd_src(instr_in[7:5]); m_p_b = rd_src(instr_in[4:2]);
        end else begin
          e_valid = 1'b1; e_has = 1'b0; e_imm = 16'h0000;
          e_op = instr_in[15:11]; e_rd = instr_in[10:8];
          e_a = rd_src(instr_in[7:5]); e_b = rd_src(instr_in[4:2]);
        end
      end
      if (wb_en) m_rf[wb_addr] = wb_data;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model compare: bundle fields matter only while valid_out is expected high.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model valid_out", {15'd0, valid_out}, {15'd0, e_valid});
      if (e_valid) begin
        check("model opcode", {11'd0, opcode_out}, {11'd0, e_op});
        check("model rdst", {13'd0, rdst_out}, {13'd0, e_rd});
        check("model rs1", rs1_data, e_a);
        check("model rs2", rs2_data, e_b);
        check("model imm", imm_out, e_imm);
        check("model has_imm", {15'd0, has_imm}, {15'd0, e_has});
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] ins, input logic st = 1'b0,
                     input logic fl = 1'b0, input logic we = 1'b0,
                     input logic [2:0] wa = 3'd0, input logic [15:0] wd = 16'h0000,
                     input logic rs = 1'b0);
    instr_valid = v; instr_in = ins; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd; reset = rs;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset valid_out", {15'd0, valid_out}, 16'h0000);
    check("reset has_imm", {15'd0, has_imm}, 16'h0000);
    check("reset opcode", {11'd0, opcode_out}, 16'h0000);
    check("reset rs1", rs1_data, 16'h0000);
    check("reset imm", imm_out, 16'h0000);

    // Write R3 then read it twice through one instruction
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 16'h00AA);
    cyc(1'b1, 16'h0A6C);
    check("wr/rd valid", {15'd0, valid_out}, 16'h0001);
    check("wr/rd opcode", {11'd0, opcode_out}, 16'h0001);
    check("wr/rd rdst", {13'd0, rdst_out}, 16'h0002);
    check("wr/rd rs1", rs1_data, 16'h00AA);
    check("wr/rd rs2", rs2_data, 16'h00AA);
    check("wr/rd has_imm", {15'd0, has_imm}, 16'h0000);
    cyc(1'b0, 16'h0000);
    check("idle valid", {15'd0, valid_out}, 16'h0000);

    // Immediate instruction on consecutive cycles
    cyc(1'b1, 16'hC100);
    check("imm first valid", {15'd0, valid_out}, 16'h0000);
    cyc(1'b1, 16'h1234);
    check("imm valid", {15'd0, valid_out}, 16'h0001);
    check("imm opcode", {11'd0, opcode_out}, 16'h0018);
    check("imm rdst", {13'd0, rdst_out}, 16'h0001);
    check("imm value", imm_out, 16'h1234);
    check("imm has_imm", {15'd0, has_imm}, 16'h0001);

    // Bypass into rs1, then R5 read from the file
    cyc(1'b1, 16'h10A0, 1'b0, 1'b0, 1'b1, 3'd5, 16'hBEEF);
    check("bypass rs1", rs1_data, 16'hBEEF);
    check("bypass rs2", rs2_data, 16'h0000);
    cyc(1'b1, 16'h1014);
    check("R5 readback", rs2_data, 16'hBEEF);

    // Source data frozen at first word despite a later R3 write and a gap
    cyc(1'b1, 16'hC160);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 16'h5555);
    check("gap valid", {15'd0, valid_out}, 16'h0000);
    cyc(1'b1, 16'h0042);
    check("frozen rs1", rs1_data, 16'h00AA);
    check("frozen imm", imm_out, 16'h0042);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 16'h00AA);

    // Flush drops a pending immediate instruction
    cyc(1'b1, 16'hC100);
    cyc(1'b1, 16'h0A6C, 1'b0, 1'b1);
    check("flush valid", {15'd0, valid_out}, 16'h0000);
    check("flush has_imm", {15'd0, has_imm}, 16'h0000);
    cyc(1'b1, 16'h0A6C);
    check("post-flush valid", {15'd0, valid_out}, 16'h0001);
    check("post-flush opcode", {11'd0, opcode_out}, 16'h0001);
    check("post-flush has_imm", {15'd0, has_imm}, 16'h0000);

    // Stall freezes the bundle for three cycles
    cyc(1'b1, 16'h0A6C);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 16'h2000 + 16'(k), 1'b1);
      check("stall valid", {15'd0, valid_out}, 16'h0001);
      check("stall opcode", {11'd0, opcode_out}, 16'h0001);
      check("stall rs1", rs1_data, 16'h00AA);
    end
    cyc(1'b1, 16'h1014);
    check("post-stall opcode", {11'd0, opcode_out}, 16'h0002);
    check("post-stall rs2", rs2_data, 16'hBEEF);

    // Reset in WAIT_IMM, with a write-back that must be ignored
    cyc(1'b1, 16'hC100);
    cyc(1'b1, 16'h0A6C, 1'b1, 1'b1, 1'b1, 3'd5, 16'h1111, 1'b1);
    check("rst valid", {15'd0, valid_out}, 16'h0000);
    check("rst opcode", {11'd0, opcode_out}, 16'h0000);
    check("rst rs2", rs2_data, 16'h0000);
    cyc(1'b1, 16'h1234);
    check("post-rst valid", {15'd0, valid_out}, 16'h0001);
    check("post-rst opcode", {11'd0, opcode_out}, 16'h0002);
    check("post-rst has_imm", {15'd0, has_imm}, 16'h0000);
    check("post-rst R5", rs2_data, 16'h0000);
    check("post-rst R1", rs1_data, 16'h0000);
    cyc(1'b0, 16'h0000);
    cyc(1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; all widths are fixed by this document.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_in  input  16  instruction word from fetch.
REQ-005 instr_valid  input  1  instr_in holds a new word this cycle.
REQ-006 stall  input  1  freeze decode; word not accepted.
REQ-007 flush  input  1  discard in-flight and pending decode.
REQ-008 wb_en  input  1  register-file write enable from write-back.
REQ-009 wb_addr  input  3  register-file write address.
REQ-010 wb_data  input  16  register-file write data.
REQ-011 valid_out  output  1  decoded bundle valid.
REQ-012 opcode_out  output  5  opcode, instr[15:11].
REQ-013 rdst_out  output  3  destination register, instr[10:8].
REQ-014 rs1_data  output  16  R[instr[7:5]] at accept time.
REQ-015 rs2_data  output  16  R[instr[4:2]] at accept time.
REQ-016 imm_out  output  16  immediate word; 0 for non-immediate instructions.
REQ-017 has_imm  output  1  bundle carries an immediate.

Function
REQ-018 Register file: 8 x 16-bit registers R0-R7, all writable; write on posedge when wb_en=1, independent of stall/flush/state.
REQ-019 Read bypass: if wb_en=1 and wb_addr equals a source field in the accept cycle, that source uses wb_data.
REQ-020 Immediate-type: instr[15:13]=3'b110; the following valid word is its 16-bit immediate.
REQ-021 FSM states: DECODE and WAIT_IMM; reset state DECODE.
REQ-022 DECODE, word accepted, non-immediate: next cycle valid_out=1, has_imm=0, imm_out=0, fields/data updated; stay DECODE.
REQ-023 DECODE, word accepted, immediate-type: latch opcode/rdst/rs1/rs2 data, go WAIT_IMM; next cycle valid_out=0.
REQ-024 WAIT_IMM, word accepted: imm_out=instr_in, has_imm=1, latched fields out, valid_out=1 next cycle; go DECODE; immediate word never decoded as an instruction.
REQ-025 A word is accepted only when instr_valid=1, stall=0, flush=0.
REQ-026 No accepted word in DECODE or WAIT_IMM (instr_valid=0, stall=0): valid_out=0 next cycle; state unchanged.
REQ-027 stall=1, flush=0: state, all outputs and latched fields hold their values (valid_out included).
REQ-028 flush=1 (priority over stall and instr_valid): next cycle valid_out=0, has_imm=0, state DECODE, latched partial instruction discarded.
REQ-029 Latency: one cycle from acceptance of last word of an instruction to valid_out=1.
REQ-030 Source data in a WAIT_IMM bundle reflects registers at first-word accept, not at immediate accept.
REQ-031 valid_out is a single-cycle pulse per instruction unless held by stall.

Reset
REQ-032 reset=1 at posedge: R0-R7=0, state DECODE, valid_out=0, has_imm=0, opcode_out=0, rdst_out=0, rs1_data=0, rs2_data=0, imm_out=0.
REQ-033 reset has priority over flush, stall, wb_en and instr_valid; no register write occurs in a reset cycle.
REQ-034 Reset in WAIT_IMM discards the pending instruction; next word after reset is decoded as an instruction.

Verification
REQ-035 wb_en=1,wb_addr=3,wb_data=16'h00AA one cycle; then instr 16'h0A6C (op 1,rdst 2,rs1 3,rs2 3) accepted -> next cycle valid_out=1, rs1_data=rs2_data=16'h00AA, has_imm=0.
REQ-036 instr 16'hC100 then 16'h1234 on consecutive valid cycles -> valid_out=0 after first, then valid_out=1, opcode_out=5'h18, rdst_out=1, imm_out=16'h1234, has_imm=1.
REQ-037 Bypass: same cycle wb_en=1,wb_addr=5,wb_data=16'hBEEF and accept instr with rs1=5 -> rs1_data=16'hBEEF next cycle; R5 reads 16'hBEEF afterwards.
REQ-038 16'hC100 accepted, flush=1 next cycle, then 16'h0A6C -> valid_out=0 during flush, then 16'h0A6C decoded as instruction, has_imm=0.
REQ-039 Valid bundle out, stall=1 for 3 cycles with changing instr_in -> all outputs frozen 3 cycles; word offered in first cycle after stall is decoded.
REQ-040 16'hC100 accepted, reset=1 next cycle -> all outputs 0, registers 0; next word 16'h1234 decoded as opcode 5'h02, not as immediate.
